// File: rtl/cgra_stream_pkg.sv
// Shared definitions for the CGRA stream blocks.
//   arb_state_t : arbiter FSM encoding (ARB_IDLE = 1'b0, ARB_LOCK = 1'b1)
//   clog2_min1  : ceil(log2(n)) but never less than 1, for index widths
package cgra_stream_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating first-one finder.
// Returns the first set request at or after ptr, wrapping modulo N_IN.
//   req   : request vector, one bit per source
//   ptr   : index where the search starts
//   found : any request set
//   idx   : winning source index (0 when found is low)
module rr_priority_pick
    import cgra_stream_pkg::*;
#(
    parameter int N_IN = 4,
    parameter int ID_W = clog2_min1(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    // The request vector is doubled so that a plain lowest-index search over
    // the bits at or above ptr naturally wraps into the second copy.
    logic [2*N_IN-1:0] req2;
    logic [2*N_IN-1:0] masked;

    // NOTE: every output of a combinational block is assigned a default
    // before any conditional update, so no path leaves a latch behind.
    always_comb begin
        req2   = {req, req};
        masked = '0;
        for (int k = 0; k < 2 * N_IN; k++) begin
            masked[k] = req2[k] && (k >= int'(ptr));
        end

        found = |req;
        idx   = '0;
        // Scan downward so the lowest masked index is the last one written.
        for (int k = 2 * N_IN - 1; k >= 0; k--) begin
            if (masked[k]) begin
                idx = (k >= N_IN) ? ID_W'(k - N_IN) : ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of N_IN valid/ready streams onto one registered output,
// with a burst lock that keeps a granted source for up to BURST beats.
//   clock, reset : clock, synchronous active-high reset
//   in_din       : packed input data, source i at [i*DATA_W +: DATA_W]
//   in_din_v     : per-source valid
//   in_din_r     : per-source ready (combinational, at most one bit high)
//   io_dout      : registered output data
//   io_dout_v    : registered output valid
//   io_dout_r    : downstream ready
//   io_grant_id  : source of the beat held in io_dout
//   io_locked    : high while a source holds the burst lock
module stream_rr_arbiter
    import cgra_stream_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int DATA_W = 32,
    parameter int BURST  = 4,
    parameter int ID_W   = clog2_min1(N_IN)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_IN*DATA_W-1:0] in_din,
    input  logic [N_IN-1:0]        in_din_v,
    output logic [N_IN-1:0]        in_din_r,
    output logic [DATA_W-1:0]      io_dout,
    output logic                   io_dout_v,
    input  logic                   io_dout_r,
    output logic [ID_W-1:0]        io_grant_id,
    output logic                   io_locked
);

    localparam logic [7:0] BURST_LAST = 8'(BURST);

    // Index increment that wraps correctly for non-power-of-two N_IN.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
        return (int'(x) == N_IN - 1) ? '0 : x + ID_W'(1);
    endfunction

    arb_state_t        state, state_n;
    logic [ID_W-1:0]   ptr, ptr_n;
    logic [ID_W-1:0]   gnt, gnt_n;
    logic [7:0]        cnt, cnt_n;

    logic              space;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   sel;
    logic              sel_ok;
    logic              take;
    logic [DATA_W-1:0] sel_data;
    logic [7:0]        cnt_inc;

    rr_priority_pick #(
        .N_IN (N_IN),
        .ID_W (ID_W)
    ) u_pick (
        .req   (in_din_v),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        space    = ~io_dout_v | io_dout_r;
        // While locked the granted source is selected even without valid, so
        // a dropped valid is seen as an early release rather than a re-pick.
        sel      = (state == ARB_LOCK) ? gnt : pick_idx;
        sel_ok   = (state == ARB_LOCK) | pick_found;
        in_din_r = '0;
        if (!reset && space && sel_ok) begin
            in_din_r[sel] = 1'b1;
        end
        take     = in_din_v[sel] & in_din_r[sel];
        sel_data = in_din[int'(sel) * DATA_W +: DATA_W];
        cnt_inc  = cnt + 8'd1;

        state_n  = state;
        ptr_n    = ptr;
        gnt_n    = gnt;
        cnt_n    = cnt;

        case (state)
            ARB_IDLE: begin
                if (take) begin
                    gnt_n = sel;
                    if (BURST == 1) begin
                        ptr_n = wrap_inc(sel);
                    end else begin
                        state_n = ARB_LOCK;
                        cnt_n   = 8'd1;
                    end
                end
            end
            ARB_LOCK: begin
                // With space low nothing moves: the lock and count are frozen.
                if (space) begin
                    if (take && cnt_inc != BURST_LAST) begin
                        cnt_n = cnt_inc;
                    end else begin
                        // Burst complete, or the owner ran dry: rotate.
                        state_n = ARB_IDLE;
                        ptr_n   = wrap_inc(gnt);
                        cnt_n   = 8'd0;
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ARB_IDLE;
            ptr         <= '0;
            gnt         <= '0;
            cnt         <= '0;
            io_dout     <= '0;
            io_dout_v   <= 1'b0;
            io_grant_id <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            gnt   <= gnt_n;
            cnt   <= cnt_n;
            // A new beat overwrites the held one in the same cycle it leaves,
            // so back-to-back transfers need no bubble.
            if (take) begin
                io_dout     <= sel_data;
                io_grant_id <= sel;
                io_dout_v   <= 1'b1;
            end else if (io_dout_r) begin
                io_dout_v   <= 1'b0;
            end
        end
    end

    assign io_locked = (state == ARB_LOCK);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: N_IN=4, BURST=4
    logic [127:0] a_din;
    logic [3:0]   a_v, a_r;
    logic [31:0]  a_dout;
    logic         a_dv, a_dr, a_locked;
    logic [1:0]   a_id;

    // Instance B: N_IN=4, BURST=2
    logic [127:0] b_din;
    logic [3:0]   b_v, b_r;
    logic [31:0]  b_dout;
    logic         b_dv, b_dr, b_locked;
    logic [1:0]   b_id;

    // Instance C: N_IN=3, BURST=1
    logic [95:0]  c_din;
    logic [2:0]   c_v, c_r;
    logic [31:0]  c_dout;
    logic         c_dv, c_dr, c_locked;
    logic [1:0]   c_id;

    stream_rr_arbiter #(.N_IN(4), .DATA_W(32), .BURST(4)) u_a (
        .clock(clock), .reset(reset),
        .in_din(a_din), .in_din_v(a_v), .in_din_r(a_r),
        .io_dout(a_dout), .io_dout_v(a_dv), .io_dout_r(a_dr),
        .io_grant_id(a_id), .io_locked(a_locked)
    );

    stream_rr_arbiter #(.N_IN(4), .DATA_W(32), .BURST(2)) u_b (
        .clock(clock), .reset(reset),
        .in_din(b_din), .in_din_v(b_v), .in_din_r(b_r),
        .io_dout(b_dout), .io_dout_v(b_dv), .io_dout_r(b_dr),
        .io_grant_id(b_id), .io_locked(b_locked)
    );

    stream_rr_arbiter #(.N_IN(3), .DATA_W(32), .BURST(1)) u_c (
        .clock(clock), .reset(reset),
        .in_din(c_din), .in_din_v(c_v), .in_din_r(c_r),
        .io_dout(c_dout), .io_dout_v(c_dv), .io_dout_r(c_dr),
        .io_grant_id(c_id), .io_locked(c_locked)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Registered outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int fair_seq [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int lock_seq [6]  = '{1, 1, 1, 0, 1, 1};
    int alt_seq  [4]  = '{2, 0, 2, 0};

    initial begin
        a_din = '0; a_v = '0; a_dr = 1'b1;
        b_din = {32'hD3, 32'hD2, 32'hD1, 32'hD0}; b_v = '0; b_dr = 1'b1;
        c_din = {32'hE2, 32'hE1, 32'hE0};         c_v = '0; c_dr = 1'b1;

        // ---------------- reset state ----------------
        reset = 1'b1;
        tick();
        tick();
        a_v = 4'hF;
        #1;
        check("rst_ready_forced", a_r, 4'b0000);
        check("rst_dout_v", a_dv, 1'b0);
        check("rst_dout", a_dout, 32'h0);
        check("rst_grant_id", a_id, 2'd0);
        check("rst_locked", a_locked, 1'b0);
        a_v = 4'h0;
        reset = 1'b0;
        #1;
        check("idle_no_valid_no_ready", a_r, 4'b0000);

        // ---------------- round-robin fairness, BURST=2 ----------------
        b_v = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("rr_id_%0d", k), b_id, fair_seq[k]);
            check($sformatf("rr_dout_%0d", k), b_dout, 32'hD0 + fair_seq[k]);
            check($sformatf("rr_valid_%0d", k), b_dv, 1'b1);
        end
        b_v = 4'h0;
        tick();
        check("rr_drain", b_dv, 1'b0);

        // ---------------- pass-through, only src2 ----------------
        for (int k = 0; k < 6; k++) begin
            a_din[2*32 +: 32] = 32'hA0 + k;
            a_v = 4'b0100;
            #1;
            check($sformatf("pt_ready_%0d", k), a_r, 4'b0100);
            tick();
            check($sformatf("pt_dout_%0d", k), a_dout, 32'hA0 + k);
            check($sformatf("pt_valid_%0d", k), a_dv, 1'b1);
            check($sformatf("pt_id_%0d", k), a_id, 2'd2);
            check($sformatf("pt_locked_%0d", k), a_locked, lock_seq[k]);
        end
        a_v = 4'h0;
        tick();
        check("pt_drain_valid", a_dv, 1'b0);
        check("pt_drain_locked", a_locked, 1'b0);
        check("pt_drain_ptr", u_a.ptr, 2'd3);

        // ---------------- early release ----------------
        a_din[1*32 +: 32] = 32'h11;
        a_v = 4'b0010;
        #1;
        check("er_ready_src1", a_r, 4'b0010);
        tick();
        check("er_dout_src1", a_dout, 32'h11);
        check("er_id_src1", a_id, 2'd1);
        check("er_locked", a_locked, 1'b1);
        a_din[3*32 +: 32] = 32'h33;
        a_v = 4'b1000;
        #1;
        check("er_ready_held_on_owner", a_r, 4'b0010);
        tick();
        check("er_released", a_locked, 1'b0);
        check("er_no_beat", a_dv, 1'b0);
        check("er_ptr", u_a.ptr, 2'd2);
        #1;
        check("er_ready_src3", a_r, 4'b1000);
        tick();
        check("er_id_src3", a_id, 2'd3);
        check("er_dout_src3", a_dout, 32'h33);
        check("er_locked_src3", a_locked, 1'b1);
        a_v = 4'h0;
        tick();
        check("er_drain_locked", a_locked, 1'b0);

        // ---------------- back-pressure mid-burst ----------------
        a_din[0 +: 32] = 32'hB0;
        a_v = 4'b0001;
        tick();
        check("bp_dout_b0", a_dout, 32'hB0);
        a_din[0 +: 32] = 32'hB1;
        tick();
        check("bp_dout_b1", a_dout, 32'hB1);
        check("bp_cnt_b1", u_a.cnt, 8'd2);
        a_dr = 1'b0;
        a_din[0 +: 32] = 32'hB2;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_ready_%0d", k), a_r, 4'b0000);
            tick();
            check($sformatf("bp_hold_dout_%0d", k), a_dout, 32'hB1);
            check($sformatf("bp_hold_valid_%0d", k), a_dv, 1'b1);
            check($sformatf("bp_hold_cnt_%0d", k), u_a.cnt, 8'd2);
            check($sformatf("bp_hold_lock_%0d", k), a_locked, 1'b1);
        end
        a_dr = 1'b1;
        #1;
        check("bp_resume_ready", a_r, 4'b0001);
        tick();
        check("bp_dout_b2", a_dout, 32'hB2);
        check("bp_valid_b2", a_dv, 1'b1);
        check("bp_cnt_b2", u_a.cnt, 8'd3);
        a_din[0 +: 32] = 32'hB3;
        tick();
        check("bp_dout_b3", a_dout, 32'hB3);
        check("bp_unlock_b3", a_locked, 1'b0);
        check("bp_ptr_b3", u_a.ptr, 2'd1);
        a_v = 4'h0;
        tick();
        check("bp_drain", a_dv, 1'b0);

        // ---------------- reset mid-burst ----------------
        a_din[2*32 +: 32] = 32'hC2;
        a_din[3*32 +: 32] = 32'hC3;
        a_v = 4'b1100;
        #1;
        check("rmb_ready_from_ptr1", a_r, 4'b0100);
        tick();
        check("rmb_locked", a_locked, 1'b1);
        check("rmb_dout", a_dout, 32'hC2);
        reset = 1'b1;
        #1;
        check("rmb_ready_in_reset", a_r, 4'b0000);
        tick();
        reset = 1'b0;
        check("rmb_valid_dropped", a_dv, 1'b0);
        check("rmb_dout_cleared", a_dout, 32'h0);
        check("rmb_locked_cleared", a_locked, 1'b0);
        check("rmb_id_cleared", a_id, 2'd0);
        check("rmb_ptr_cleared", u_a.ptr, 2'd0);
        #1;
        check("rmb_ready_lowest", a_r, 4'b0100);
        tick();
        check("rmb_first_id", a_id, 2'd2);
        check("rmb_first_dout", a_dout, 32'hC2);
        a_v = 4'h0;
        tick();

        // ---------------- wrap with N_IN=3, BURST=1 ----------------
        c_v = 3'b010;
        #1;
        check("wr_ready_src1", c_r, 3'b010);
        tick();
        check("wr_id_src1", c_id, 2'd1);
        check("wr_ptr", u_c.ptr, 2'd2);
        c_v = 3'b101;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("wr_id_%0d", k), c_id, alt_seq[k]);
            check($sformatf("wr_dout_%0d", k), c_dout, 32'hE0 + alt_seq[k]);
            check($sformatf("wr_nolock_%0d", k), c_locked, 1'b0);
        end
        c_v = 3'b000;
        tick();
        check("wr_drain", c_dv, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
